// File: rtl/fifo_read_adapter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_adapter
// Description : Read-side stage in the read clock domain, directly downstream
//               of the async FIFO. Converts the FIFO pull interface
//               (fifo_rpull / fifo_rempty / fifo_rdata) into a registered
//               valid/ready stream with a 2-entry output buffer (output
//               register plus skid register). Sustains one beat per cycle.
//               fifo_rpull depends only on registered state, fifo_rempty,
//               flush and rst -- never on m_ready.
//
// Ports       : clk          single clock (FIFO read clock)
//               rst          synchronous active-high reset
//               fifo_rempty  FIFO empty flag
//               fifo_rdata   FIFO head word, valid while !fifo_rempty
//               fifo_rpull   pop request; word consumed at this clk edge
//               flush        synchronous drop of all buffered words
//               m_valid      output word valid (registered)
//               m_ready      downstream accept
//               m_data       output word (registered)
//               beat_cnt     accepted-beat counter (optional)
//
// Options     : FIFO_RD_ADAPTER_STAT_EN -- when defined, adds the beat_cnt
//               port and its counter. Undefined: port and logic absent.
//
// Revision    : 1.0  initial release
// ============================================================================
module fifo_read_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rpull,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_ADAPTER_STAT_EN
    ,
    output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

    // Reject nonsensical widths at elaboration time.
    generate
        if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
            $error("fifo_read_adapter: DATA_WIDTH and CNT_WIDTH must be >= 1");
        end
    endgenerate

    // Occupancy-encoded state: number of words held in out/skid registers.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q,   out_d;
    logic [DATA_WIDTH-1:0] skid_q,  skid_d;

    logic w_push;
    logic w_pop;

    // Pull whenever there is room. Flush suppresses the pull so a word is
    // never taken out of the FIFO only to be dropped by the flush.
    assign w_push     = !rst && !flush && !fifo_rempty && (state_q != ST_TWO);
    assign w_pop      = m_valid && m_ready;

    assign fifo_rpull = w_push;
    assign m_valid    = (state_q != ST_EMPTY);
    assign m_data     = out_q;

    // ------------------------------------------------------------------------
    // Next-state / datapath
    // fifo_rdata is only ever captured under w_push, which implies
    // !fifo_rempty, so undefined data on an empty FIFO never enters the
    // registers.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        if (flush) begin
            // Buffered words are dropped; register contents are left as-is
            // since m_valid masks them.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        state_d = ST_ONE;
                        out_d   = fifo_rdata;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        // Head leaves while the new word takes its place.
                        out_d   = fifo_rdata;
                    end else if (w_push) begin
                        state_d = ST_TWO;
                        skid_d  = fifo_rdata;
                    end else if (w_pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // No push is possible here; only drain into out reg.
                    if (w_pop) begin
                        state_d = ST_ONE;
                        out_d   = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FIFO_RD_ADAPTER_STAT_EN
    // ------------------------------------------------------------------------
    // Accepted-beat counter. Counts every handshake, including one that
    // coincides with a flush. Wraps naturally; cleared only by rst.
    // ------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] beat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else if (w_pop) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_adapter
// Description : Self-checking bench for fifo_read_adapter. The FIFO is a
//               queue inside the bench; a queue-based occupancy model of the
//               2-entry buffer predicts every output each cycle. Directed
//               table vectors cover backpressure, empty and flush cases.
//               Define FIFO_RD_ADAPTER_STAT_EN to exercise beat_cnt.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_read_adapter;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_rempty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rpull;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_ADAPTER_STAT_EN
    logic [CW-1:0] beat_cnt;
`endif

    fifo_read_adapter #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rpull  (fifo_rpull),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data)
`ifdef FIFO_RD_ADAPTER_STAT_EN
        ,
        .beat_cnt    (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO contents and reference model of the adapter's buffered words.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] mq[$];
    int            mcnt = 0;
    bit            mon  = 1'b0;

    // Values sampled from the DUT in the most recent step.
    logic          s_pull, s_valid;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_cnt;

    typedef struct {
        logic          rst_v;
        logic          hide_v;
        logic          ready_v;
        logic          flush_v;
        logic          exp_pull;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, sample and check
    // against the model, cross the rising edge, update FIFO and model.
    task automatic step(input logic r, input logic h, input logic rd, input logic fl);
        logic          e_pull, e_valid;
        logic [DW-1:0] e_data, head;
        rst         = r;
        m_ready     = rd;
        flush       = fl;
        fifo_rempty = h || (fq.size() == 0);
        fifo_rdata  = fifo_rempty ? {DW{1'bx}} : fq[0];
        head        = fifo_rempty ? '0 : fq[0];
        #1;
        s_pull  = fifo_rpull;
        s_valid = m_valid;
        s_data  = m_data;
`ifdef FIFO_RD_ADAPTER_STAT_EN
        s_cnt   = beat_cnt;
`else
        s_cnt   = '0;
`endif
        e_valid = (mq.size() > 0);
        e_data  = e_valid ? mq[0] : '0;
        e_pull  = !r && !fl && !fifo_rempty && (mq.size() < 2);
        if (mon) begin
            chk("model_pull",  {63'd0, s_pull},  {63'd0, e_pull});
            chk("model_valid", {63'd0, s_valid}, {63'd0, e_valid});
            if (e_valid) chk("model_data", {32'd0, s_data}, {32'd0, e_data});
`ifdef FIFO_RD_ADAPTER_STAT_EN
            chk("model_cnt", {56'd0, s_cnt}, {56'd0, CW'(mcnt)});
`endif
        end
        @(posedge clk);
        if (s_pull && fq.size() > 0) void'(fq.pop_front());
        if (r) begin
            mq.delete();
            mcnt = 0;
            mon  = 1'b1;
        end else begin
            if (e_valid && rd) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (fl) mq.delete();
            else if (e_pull) mq.push_back(head);
        end
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, input logic h, input logic rd, input logic fl,
                                input logic ep, input logic ev, input logic [DW-1:0] ed);
        vec_t v;
        v.rst_v = r; v.hide_v = h; v.ready_v = rd; v.flush_v = fl;
        v.exp_pull = ep; v.exp_valid = ev; v.exp_data = ed;
        return v;
    endfunction

    task automatic run_table(input string nm);
        foreach (tbl[i]) begin
            step(tbl[i].rst_v, tbl[i].hide_v, tbl[i].ready_v, tbl[i].flush_v);
            chk({nm, "_pull"},  {63'd0, s_pull},  {63'd0, tbl[i].exp_pull});
            chk({nm, "_valid"}, {63'd0, s_valid}, {63'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) chk({nm, "_data"}, {32'd0, s_data}, {32'd0, tbl[i].exp_data});
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        fifo_rempty = 1'b1; fifo_rdata = '0;
        @(negedge clk);

        // 1: reset with non-empty FIFO
        for (int k = 0; k < 8; k++) fq.push_back(DW'(32'h11 + k));
        step(1, 0, 1, 0);
        chk("rst_pull",  {63'd0, s_pull}, 64'd0);
        step(1, 0, 1, 0);
        chk("rst_pull2", {63'd0, s_pull}, 64'd0);
        chk("rst_valid", {63'd0, s_valid}, 64'd0);
        chk("rst_data",  {32'd0, s_data}, 64'd0);

        // 2: streaming 0x11..0x18
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 1, 0);
            chk("stream_pull",  {63'd0, s_pull},  {63'd0, (k < 8)});
            chk("stream_valid", {63'd0, s_valid}, {63'd0, (k >= 1 && k <= 8)});
            if (k >= 1 && k <= 8) chk("stream_data", {32'd0, s_data}, 64'(32'h10 + k));
        end

        // 3: backpressure
        fq.push_back(32'hA); fq.push_back(32'hB); fq.push_back(32'hC);
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'hA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'hA));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 32'hB));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'hC));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0));
        run_table("bp");

        // 4: empty boundary, then a single word
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 1, 0);
            chk("empty_pull",  {63'd0, s_pull},  64'd0);
            chk("empty_valid", {63'd0, s_valid}, 64'd0);
            chk("empty_noX",   {63'd0, $isunknown(s_data)}, 64'd0);
        end
        fq.push_back(32'h5A);
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'h5A));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0));
        run_table("one");

        // 5: flush while holding two words
        fq.push_back(32'h1); fq.push_back(32'h2); fq.push_back(32'h3);
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 32'h1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'h3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0));
        run_table("flush");

        // Randomised traffic against the model
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) != 0 && fq.size() < 6) fq.push_back(DW'($urandom));
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 19) == 0));
        end

`ifdef FIFO_RD_ADAPTER_STAT_EN
        // 6: 300 accepted beats wrap an 8-bit counter to 44
        fq.delete();
        step(1, 1, 0, 0);
        for (int k = 0; k < 310; k++) fq.push_back(DW'($urandom));
        guard = 0;
        while (mcnt < 300 && guard < 4000) begin
            step(0, 0, $urandom_range(0, 1), 0);
            guard++;
        end
        chk("stat_timeout", {63'd0, (guard >= 4000)}, 64'd0);
        step(0, 1, 0, 0);
        chk("stat_300", {56'd0, s_cnt}, 64'd44);
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        chk("stat_flush", {56'd0, s_cnt}, 64'd44);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("stat_rst", {56'd0, s_cnt}, 64'd0);
`else
        guard = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
